// File: rtl/sweep_pkg.sv
// Shared state encoding and mode constants for the frequency sweep sequencer.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    // The unused encoding 3 behaves exactly like single.
    function automatic logic [1:0] mode_norm(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            MODE_REPEAT:   r = MODE_REPEAT;
            MODE_PINGPONG: r = MODE_PINGPONG;
            default:       r = MODE_SINGLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sweep_sequencer_dwell_timer.sv
// Loadable down-counter that times how long the sequencer holds each frequency point.
module dwell_timer
    import sweep_pkg::*;
#(
    parameter int WL = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          load,
    input  logic [WL-1:0] load_val,
    input  logic          en,
    output logic          zero,
    output logic          last
);

    logic [WL-1:0] cnt_r;

    // Counter: clear, reload, or count down towards zero while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - WL'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);
    // last marks the decrement that expires the count
    assign last = (cnt_r == WL'(1));

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency sweep sequencer: walks a registered frequency word from start to stop,
// holding each point for a programmable dwell, in single, repeat or ping-pong mode.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int FREQ_WL  = 8,
    parameter int DWELL_WL = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [FREQ_WL-1:0]  start_freq,
    input  logic [FREQ_WL-1:0]  stop_freq,
    input  logic [FREQ_WL-1:0]  step,
    input  logic [DWELL_WL-1:0] dwell,
    output logic [FREQ_WL-1:0]  freq,
    output logic                load,
    output logic                busy,
    output logic                done
);

    state_t state_r, state_s;

    logic [FREQ_WL-1:0]  freq_r, freq_s;
    logic                load_r, load_s;
    logic                done_r, done_s;
    logic [FREQ_WL-1:0]  start_r, stop_r, step_r;
    logic [FREQ_WL-1:0]  target_r, target_s, pp_target_s;
    logic [DWELL_WL-1:0] dwell_r, tmr_val_s;
    logic [1:0]          mode_r;
    logic                dir_up_r, dir_up_s;
    logic                capture_s, at_end_s;
    logic                tmr_load_s, tmr_dec_s, tmr_zero_s, tmr_last_s;

    // One step toward tgt in FREQ_WL+1 bits so overflow/underflow saturates at tgt.
    function automatic logic [FREQ_WL-1:0] step_toward(
        input logic [FREQ_WL-1:0] cur,
        input logic [FREQ_WL-1:0] stp,
        input logic [FREQ_WL-1:0] tgt,
        input logic               up
    );
        logic [FREQ_WL:0]   ext;
        logic [FREQ_WL-1:0] r;
        if (up) begin
            ext = {1'b0, cur} + {1'b0, stp};
            if (ext >= {1'b0, tgt}) begin
                r = tgt;
            end else begin
                r = ext[FREQ_WL-1:0];
            end
        end else begin
            ext = {1'b0, cur} - {1'b0, stp};
            if (ext[FREQ_WL] || (ext[FREQ_WL-1:0] <= tgt)) begin
                r = tgt;
            end else begin
                r = ext[FREQ_WL-1:0];
            end
        end
        return r;
    endfunction

    // A zero step is a one-point sweep, so it counts as already at the endpoint.
    assign at_end_s    = (freq_r == target_r) || (step_r == '0);
    assign pp_target_s = (target_r == stop_r) ? start_r : stop_r;

    // Next-state, next-output and timer control
    always_comb begin
        state_s    = state_r;
        freq_s     = freq_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        target_s   = target_r;
        dir_up_s   = dir_up_r;
        capture_s  = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = dwell_r;
        tmr_dec_s  = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        capture_s  = 1'b1;
                        freq_s     = start_freq;
                        load_s     = 1'b1;
                        target_s   = stop_freq;
                        dir_up_s   = (start_freq <= stop_freq);
                        tmr_load_s = 1'b1;
                        tmr_val_s  = dwell;
                        state_s    = (dwell == '0) ? ST_STEP : ST_DWELL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DWELL: begin
                    if (en) begin
                        tmr_dec_s = 1'b1;
                        state_s   = (tmr_last_s || tmr_zero_s) ? ST_STEP : ST_DWELL;
                    end else begin
                        state_s = ST_DWELL;
                    end
                end
                ST_STEP: begin
                    if (en) begin
                        load_s     = 1'b1;
                        tmr_load_s = 1'b1;
                        state_s    = (dwell_r == '0) ? ST_STEP : ST_DWELL;
                        if (!at_end_s) begin
                            freq_s = step_toward(freq_r, step_r, target_r, dir_up_r);
                        end else begin
                            case (mode_norm(mode_r))
                                MODE_REPEAT: begin
                                    freq_s   = start_r;
                                    target_s = stop_r;
                                    dir_up_s = (start_r <= stop_r);
                                end
                                MODE_PINGPONG: begin
                                    target_s = pp_target_s;
                                    dir_up_s = !dir_up_r;
                                    freq_s   = step_toward(freq_r, step_r, pp_target_s, !dir_up_r);
                                end
                                default: begin
                                    state_s    = ST_IDLE;
                                    load_s     = 1'b0;
                                    tmr_load_s = 1'b0;
                                    done_s     = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        state_s = ST_STEP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, output and shadow configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            freq_r   <= '0;
            load_r   <= 1'b0;
            done_r   <= 1'b0;
            target_r <= '0;
            dir_up_r <= 1'b0;
            start_r  <= '0;
            stop_r   <= '0;
            step_r   <= '0;
            dwell_r  <= '0;
            mode_r   <= 2'd0;
        end else begin
            state_r  <= state_s;
            freq_r   <= freq_s;
            load_r   <= load_s;
            done_r   <= done_s;
            target_r <= target_s;
            dir_up_r <= dir_up_s;
            if (capture_s) begin
                start_r <= start_freq;
                stop_r  <= stop_freq;
                step_r  <= step;
                dwell_r <= dwell;
                mode_r  <= mode;
            end
        end
    end

    dwell_timer #(
        .WL (DWELL_WL)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (abort),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_dec_s),
        .zero     (tmr_zero_s),
        .last     (tmr_last_s)
    );

    assign freq = freq_r;
    assign load = load_r;
    assign done = done_r;
    assign busy = (state_r != ST_IDLE);

endmodule

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter FREQ_WL, default 8: frequency word width, matching the freq2trig input.
REQ-002 SHALL have parameter DWELL_WL, default 16: dwell counter width.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: advance enable; low freezes the dwell count and the state.
REQ-006 SHALL have port start, input, 1: single-cycle sweep request.
REQ-007 SHALL have port abort, input, 1: terminate the sweep.
REQ-008 SHALL have port mode, input, 2: 0 single, 1 repeat, 2 ping-pong, 3 treated as single.
REQ-009 SHALL have ports start_freq, stop_freq, step, input, FREQ_WL each: sweep endpoints and increment.
REQ-010 SHALL have port dwell, input, DWELL_WL: hold time per point minus one.
REQ-011 SHALL have port freq, output, FREQ_WL: registered frequency word to freq2trig.
REQ-012 SHALL have port load, output, 1: one-cycle pulse to sine_gen when freq changes.
REQ-013 SHALL have port busy, output, 1: high when not IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle sweep-complete pulse.

Function
REQ-015 SHALL implement the states IDLE, DWELL and STEP.
REQ-016 In IDLE, start=1 and abort=0 SHALL:
- capture start_freq, stop_freq, step, dwell and mode into shadow registers;
- set freq=start_freq and load=1 on the next edge;
- enter DWELL.
REQ-017 Config inputs SHALL be ignored after capture; writes mid-sweep take effect only at the next start.
REQ-018 Direction SHALL be up if start_freq<=stop_freq, else down, fixed at capture.
REQ-019 In DWELL, the counter SHALL load dwell on each freq update and decrement once per en=1 cycle.
REQ-020 A point SHALL be held for exactly dwell+1 enabled cycles; dwell=0 gives one enabled cycle per point.
REQ-021 On expiry, DWELL SHALL go to STEP, and STEP SHALL resolve in one cycle.
REQ-022 In STEP with freq != target, freq SHALL become freq±step, computed in FREQ_WL+1 bits and saturated to the target, with load=1; the state returns to DWELL.
REQ-023 In STEP with freq == target, the action SHALL depend on mode:
- single: enter IDLE, done=1 for one cycle, freq holds;
- repeat: freq=start, load=1;
- ping-pong: swap target and direction, then step toward the new target.
REQ-024 step=0 or start_freq==stop_freq SHALL be a one-point sweep: in single mode, done after one dwell; in the other modes, load re-pulses every dwell+1 enabled cycles.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort SHALL force IDLE on the next edge with no done pulse, and freq SHALL hold its value.
REQ-027 When abort and start are asserted together, abort SHALL win.
REQ-028 load and freq SHALL change on the same edge; the load-to-freq latency is 0.
REQ-029 load SHALL never be asserted in IDLE.
REQ-030 busy SHALL be combinational from the state register only.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE with freq=0, load=0, done=0, busy=0, and the dwell counter and all shadow registers at 0.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-033 After release, the block SHALL wait for a new start.

Structure
REQ-034 Package sweep_pkg SHALL hold the state encoding and the mode constants MODE_SINGLE=0, MODE_REPEAT=1, MODE_PINGPONG=2.
REQ-035 Sub-module dwell_timer SHALL be a loadable down-counter with an enable and a zero flag, instantiated once.
REQ-036 The block SHALL have no other hierarchy and no combinational path from inputs to freq or load.

Verification
REQ-037 Single up-sweep: start=10, stop=40, step=10, dwell=2, en=1, single mode -> freq 10,20,30,40, each held 3 cycles, load on each change, done 3 cycles after 40.
REQ-038 Saturation, down direction: start=50, stop=5, step=20 -> freq 50,30,10,5, then done.
REQ-039 Ping-pong: start=0, stop=4, step=2, dwell=0 -> freq 0,2,4,2,0,2,... with no done; abort mid-run -> IDLE next edge, freq held, done=0.
REQ-040 en gating and shadowing: en toggling 1/0 with dwell=3 -> each point held 4 en-high cycles; changing stop_freq mid-sweep -> no effect.
REQ-041 Simultaneous events: start and abort in the same cycle from IDLE -> busy stays 0, no load; start while busy -> ignored.
REQ-042 Reset mid-sweep: rst_n pulsed low during DWELL -> freq=0, busy=0 immediately, no done; a new start works afterwards.
